branch_target_predictor: RTL and testbench

Dynamic branch predictor for the RV32I pipeline. Supplies the IF-stage predicted next PC and taken flag, and learns from branches resolved in EX. It is built from a direct-mapped branch target buffer with one 2-bit saturating counter per entry. Its `predict_target` output feeds the next-PC selection, which overrides it on br/jalr/jal redirects. It also keeps branch and mispredict performance counters.

---
 rtl/branch_target_predictor.sv | 98 +++++++++
 tb/tb_branch_target_predictor.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with per-entry 2-bit saturating counters.
// Zero-latency lookup from the fetch PC, one-cycle learning from branches resolved in EX.
module branch_target_predictor #(
  parameter int unsigned ENTRIES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_if,
  output logic [31:0] predict_target,
  output logic        predict_taken,
  input  logic        ex_br_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_br_taken,
  input  logic [31:0] ex_br_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        ex_mispredict,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  logic [ENTRIES-1:0]       valid_q;
  logic [ENTRIES-1:0][1:0]  cnt_q;
  logic [TAG_W-1:0]         tag_q [ENTRIES];
  logic [31:0]              tgt_q [ENTRIES];

  logic [IDX_W-1:0] if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX_W-1:0] ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic [1:0]       ex_cnt;
  logic [1:0]       ex_cnt_next;

  // Byte offset of the PC carries no information for 4-byte instructions.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_if[1:0], ex_pc[1:0]};

  // Lookup
  always_comb begin
    if_idx         = pc_if[IDX_W+1:2];
    if_tag         = pc_if[31:IDX_W+2];
    if_hit         = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    predict_taken  = if_hit && cnt_q[if_idx][1];
    predict_target = predict_taken ? tgt_q[if_idx] : pc_if + 32'd4;
  end

  // Resolution side
  always_comb begin
    ex_idx      = ex_pc[IDX_W+1:2];
    ex_tag      = ex_pc[31:IDX_W+2];
    ex_hit      = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    ex_cnt      = cnt_q[ex_idx];
    ex_cnt_next = ex_cnt;
    if (ex_br_taken) begin
      if (ex_cnt != 2'b11) ex_cnt_next = ex_cnt + 2'd1;
    end else begin
      if (ex_cnt != 2'b00) ex_cnt_next = ex_cnt - 2'd1;
    end
    ex_mispredict = ex_br_valid &&
                    ((ex_pred_taken != ex_br_taken) ||
                     (ex_br_taken && (ex_pred_target != ex_br_target)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= '0;
      cnt_q         <= {ENTRIES{2'b01}};
      br_count      <= '0;
      mispred_count <= '0;
    end else begin
      if (ex_br_valid) begin
        br_count <= br_count + 32'd1;
        if (ex_hit) begin
          cnt_q[ex_idx] <= ex_cnt_next;
        end else if (ex_br_taken) begin
          valid_q[ex_idx] <= 1'b1;
          cnt_q[ex_idx]   <= 2'b10;
        end
      end
      if (ex_mispredict) mispred_count <= mispred_count + 32'd1;
    end
  end

  // Tag/target are unreset; writes during reset are harmless since valid is held clear.
  // A taken branch either refreshes a hit (tag already equal) or allocates.
  always_ff @(posedge clk) begin
    if (ex_br_valid && ex_br_taken) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= ex_br_target;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: vector table for learning,
// aliasing and same-cycle behaviour, plus hand sequences around async reset.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_if;
  logic [31:0] predict_target;
  logic        predict_taken;
  logic        ex_br_valid;
  logic [31:0] ex_pc;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        ex_mispredict;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(.ENTRIES(64)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_if          (pc_if),
    .predict_target (predict_target),
    .predict_taken  (predict_taken),
    .ex_br_valid    (ex_br_valid),
    .ex_pc          (ex_pc),
    .ex_br_taken    (ex_br_taken),
    .ex_br_target   (ex_br_target),
    .ex_pred_taken  (ex_pred_taken),
    .ex_pred_target (ex_pred_target),
    .ex_mispredict  (ex_mispredict),
    .br_count       (br_count),
    .mispred_count  (mispred_count)
  );

  typedef struct {
    logic [31:0] pc;
    logic        upd;
    logic [31:0] expc;
    logic        tkn;
    logic [31:0] tgt;
    logic        ptkn;
    logic [31:0] ptgt;
    logic        e_pt;
    logic [31:0] e_tg;
    logic        e_mis;
    logic [31:0] e_br;
    logic [31:0] e_mp;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  function automatic vec_t mk(logic [31:0] pc, logic upd, logic [31:0] expc, logic tkn,
                              logic [31:0] tgt, logic ptkn, logic [31:0] ptgt, logic e_pt,
                              logic [31:0] e_tg, logic e_mis, logic [31:0] e_br,
                              logic [31:0] e_mp);
    vec_t v;
    v.pc = pc; v.upd = upd; v.expc = expc; v.tkn = tkn; v.tgt = tgt; v.ptkn = ptkn;
    v.ptgt = ptgt; v.e_pt = e_pt; v.e_tg = e_tg; v.e_mis = e_mis; v.e_br = e_br;
    v.e_mp = e_mp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // Expected values are sampled on the falling edge, before the next update edge.
    //              pc            upd expc          tkn tgt         ptk ptgt          pt tg            mis br  mp
    vecs[0]  = mk(32'h100, 0, 32'h100, 0, 32'h0,  0, 32'h0,   0, 32'h104, 0, 0,  0);
    vecs[1]  = mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 0,  0);
    vecs[2]  = mk(32'h100, 0, 32'h100, 0, 32'h0,  0, 32'h0,   1, 32'h80,  0, 1,  1);
    vecs[3]  = mk(32'h100, 1, 32'h100, 0, 32'h0,  1, 32'h80,  1, 32'h80,  1, 1,  1);
    vecs[4]  = mk(32'h100, 1, 32'h100, 0, 32'h0,  0, 32'h104, 0, 32'h104, 0, 2,  2);
    vecs[5]  = mk(32'h100, 1, 32'h100, 0, 32'h0,  0, 32'h104, 0, 32'h104, 0, 3,  2);
    vecs[6]  = mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 4,  2);
    vecs[7]  = mk(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104, 0, 32'h104, 1, 5,  3);
    vecs[8]  = mk(32'h100, 0, 32'h100, 0, 32'h0,  0, 32'h0,   1, 32'h80,  0, 6,  4);
    vecs[9]  = mk(32'h100, 1, 32'h100, 1, 32'h88, 1, 32'h80,  1, 32'h80,  1, 6,  4);
    vecs[10] = mk(32'h100, 1, 32'h100, 1, 32'h88, 1, 32'h88,  1, 32'h88,  0, 7,  5);
    vecs[11] = mk(32'h100, 0, 32'h100, 1, 32'h88, 0, 32'h0,   1, 32'h88,  0, 8,  5);
    vecs[12] = mk(32'h100, 1, 32'h100, 0, 32'h0,  1, 32'h88,  1, 32'h88,  1, 8,  5);
    vecs[13] = mk(32'h100, 0, 32'h100, 0, 32'h0,  0, 32'h0,   1, 32'h88,  0, 9,  6);
    vecs[14] = mk(32'h200, 0, 32'h200, 0, 32'h0,  0, 32'h0,   0, 32'h204, 0, 9,  6);
    vecs[15] = mk(32'h200, 1, 32'h200, 0, 32'h0,  0, 32'h204, 0, 32'h204, 0, 9,  6);
    vecs[16] = mk(32'h100, 0, 32'h100, 0, 32'h0,  0, 32'h0,   1, 32'h88,  0, 10, 6);
    vecs[17] = mk(32'h200, 1, 32'h200, 1, 32'h40, 0, 32'h204, 0, 32'h204, 1, 10, 6);
    vecs[18] = mk(32'h200, 0, 32'h200, 0, 32'h0,  0, 32'h0,   1, 32'h40,  0, 11, 7);
    vecs[19] = mk(32'h100, 0, 32'h100, 0, 32'h0,  0, 32'h0,   0, 32'h104, 0, 11, 7);
    vecs[20] = mk(32'h300, 1, 32'h300, 1, 32'h10, 0, 32'h304, 0, 32'h304, 1, 11, 7);
    vecs[21] = mk(32'h300, 0, 32'h300, 0, 32'h0,  0, 32'h0,   1, 32'h10,  0, 12, 8);
    vecs[22] = mk(32'h104, 0, 32'h104, 0, 32'h0,  0, 32'h0,   0, 32'h108, 0, 12, 8);
    vecs[23] = mk(32'hFFFFFFFC, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0,   0, 12, 8);
    vecs[24] = mk(32'h302, 0, 32'h302, 0, 32'h0,  0, 32'h0,   1, 32'h10,  0, 12, 8);

    rst_n = 1'b0;
    pc_if = 32'h100;
    ex_br_valid = 1'b0; ex_pc = '0; ex_br_taken = 1'b0; ex_br_target = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      pc_if          = vecs[i].pc;
      ex_br_valid    = vecs[i].upd;
      ex_pc          = vecs[i].expc;
      ex_br_taken    = vecs[i].tkn;
      ex_br_target   = vecs[i].tgt;
      ex_pred_taken  = vecs[i].ptkn;
      ex_pred_target = vecs[i].ptgt;
      @(negedge clk);
      chk($sformatf("v%0d predict_taken", i), {31'b0, predict_taken}, {31'b0, vecs[i].e_pt});
      chk($sformatf("v%0d predict_target", i), predict_target, vecs[i].e_tg);
      chk($sformatf("v%0d ex_mispredict", i), {31'b0, ex_mispredict}, {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d br_count", i), br_count, vecs[i].e_br);
      chk($sformatf("v%0d mispred_count", i), mispred_count, vecs[i].e_mp);
    end

    // Asynchronous reset between edges with 0x300 learned.
    @(posedge clk);
    #1;
    ex_br_valid = 1'b0;
    pc_if = 32'h300;
    #2;
    chk("pre_reset predict_taken", {31'b0, predict_taken}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset predict_taken", {31'b0, predict_taken}, 32'd0);
    chk("async_reset predict_target", predict_target, 32'h304);
    chk("async_reset br_count", br_count, 32'd0);
    chk("async_reset mispred_count", mispred_count, 32'd0);

    // Update presented while reset is held must be discarded.
    ex_br_valid = 1'b1; ex_pc = 32'h300; ex_br_taken = 1'b1; ex_br_target = 32'h55;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h304;
    @(posedge clk);
    #1;
    ex_br_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("held_reset predict_taken", {31'b0, predict_taken}, 32'd0);
    chk("held_reset predict_target", predict_target, 32'h304);
    chk("held_reset br_count", br_count, 32'd0);

    // First edge after deassertion applies the update.
    @(posedge clk);
    #1;
    ex_br_valid = 1'b1; ex_pc = 32'h300; ex_br_taken = 1'b1; ex_br_target = 32'h20;
    ex_pred_taken = 1'b0; ex_pred_target = 32'h304;
    @(posedge clk);
    #1;
    ex_br_valid = 1'b0;
    #1;
    chk("post_reset predict_taken", {31'b0, predict_taken}, 32'd1);
    chk("post_reset predict_target", predict_target, 32'h20);
    chk("post_reset br_count", br_count, 32'd1);
    chk("post_reset mispred_count", mispred_count, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
